// File: rtl/spi_ram_master.sv
// spi_ram_master
//   Host-side SPI master for the shared-clock SPI RAM slave. Each accepted host
//   request becomes two 10-bit command frames:
//     write : {2'b00,addr} then {2'b01,wdata}
//     read  : {2'b10,addr} then {2'b11,8'h00}, followed by an 8-bit MISO capture
//   Completion is reported with a one-cycle rsp_valid pulse.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   req_valid  in   host request present
//   req_ready  out  high only in IDLE
//   req_wr     in   1 = write, 0 = read
//   req_addr   in   RAM address
//   req_wdata  in   write data (ignored for reads)
//   rsp_valid  out  one-cycle completion pulse
//   rsp_wr     out  type of completed transaction
//   rsp_rdata  out  read data, updated only on read completion
//   busy       out  ~req_ready
//   MOSI       out  serial command, MSB first
//   SS_n       out  slave select, active-low
//   MISO       in   serial read data, MSB first
//
// State table
//   IDLE    | SS_n high, waiting for a request; also the final gap cycle of a transaction
//   LEAD    | SS_n low, MOSI shows the command MSB for LEAD_CYC cycles
//   SHIFT   | one command bit per cycle, MSB first
//   TURN    | read-data frame only: SS_n low, MOSI low, waiting for slave data
//   CAPTURE | shift MISO in, MSB first, DATA_W cycles
//   GAP     | SS_n high between frames
//
// All parameters are expected to be >= 1.
module spi_ram_master #(
    parameter int LEAD_CYC = 2,
    parameter int TURN_CYC = 2,
    parameter int GAP_CYC  = 1,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              MOSI,
    output logic              SS_n,
    input  logic              MISO
);

    localparam int CMD_W   = DATA_W + 2;
    localparam int MAX_LEN = CMD_W + LEAD_CYC + TURN_CYC + GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TURN,
        CAPTURE,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                frame_q, frame_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [DATA_W-1:0]   shift_q, shift_d;

    logic                ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_wr_q, rsp_wr_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                end_frame;
    logic                finish;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        cmd_d       = cmd_q;
        shift_d     = shift_q;
        rsp_valid_d = 1'b0;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        end_frame   = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    frame_d = 1'b0;
                    cmd_d   = {~req_wr, 1'b0, req_addr};
                    state_d = LEAD;
                    cnt_d   = CNT_W'(LEAD_CYC - 1);
                end
            end
            LEAD: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(CMD_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    if (frame_q && !wr_q) begin
                        state_d = TURN;
                        cnt_d   = CNT_W'(TURN_CYC - 1);
                    end else begin
                        end_frame = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    cmd_d = cmd_q << 1;
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                shift_d = {shift_q[DATA_W-2:0], MISO};
                if (cnt_q == '0) begin
                    end_frame = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (!frame_q) begin
                        frame_d = 1'b1;
                        cmd_d   = wr_q ? {2'b01, wdata_q} : {2'b11, {DATA_W{1'b0}}};
                        state_d = LEAD;
                        cnt_d   = CNT_W'(LEAD_CYC - 1);
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The IDLE cycle carrying rsp_valid already has SS_n high, so it
        // stands in for the last gap cycle after frame 2.
        if (end_frame) begin
            if (!frame_q) begin
                state_d = GAP;
                cnt_d   = CNT_W'(GAP_CYC - 1);
            end else if (GAP_CYC > 1) begin
                state_d = GAP;
                cnt_d   = CNT_W'(GAP_CYC - 2);
            end else begin
                finish = 1'b1;
            end
        end

        if (finish) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_wr_d    = wr_q;
            if (!wr_q) begin
                rsp_rdata_d = shift_d;
            end
        end

        // Outputs are registered from the next state so they line up with it.
        ss_n_d  = !(state_d inside {LEAD, SHIFT, TURN, CAPTURE});
        mosi_d  = (state_d == LEAD || state_d == SHIFT) ? cmd_d[CMD_W-1] : 1'b0;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_q     <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a behavioural SPI RAM slave, a MOSI frame
// scoreboard and a response scoreboard (type, data, latency).
module tb_spi_ram_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_wr;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       MOSI;
    logic       SS_n;
    logic       MISO = 1'b0;

    spi_ram_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic       wr;
        logic [7:0] rd;
        logic [7:0] lat;
    } rsp_t;

    rsp_t       exp_rsp[$];
    logic [9:0] exp_frm[$];
    int         acc_q[$];
    int         n_acc = 0;
    int         last_acc = 0;
    int         last_rsp_cyc = 0;
    int         n_rsp = 0;
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] last_rd = 8'h00;

    // slave model state
    logic [7:0] smem [256] = '{default: 8'h00};
    int         scnt = 0;
    logic [8:0] ssh = 9'h000;
    logic [7:0] saddr = 8'h00;
    logic [7:0] sbyte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic frame_mon(input logic [9:0] f);
        logic [31:0] e;
        e = 'x;
        if (exp_frm.size() > 0) e = 32'(exp_frm.pop_front());
        check("mosi_frame", 32'(f), e);
    endtask

    // Slave: edge counter since SS_n fell; bits at counts 2..11, data out from count 13.
    always @(posedge clk) begin
        if (rst || SS_n) begin
            scnt <= 0;
            MISO <= 1'b0;
        end else begin
            scnt <= scnt + 1;
            if (scnt >= 2 && scnt <= 10) ssh <= {ssh[7:0], MOSI};
            if (scnt == 11) begin
                frame_mon({ssh, MOSI});
                case (ssh[8:7])
                    2'b00, 2'b10: saddr <= {ssh[6:0], MOSI};
                    2'b01:        smem[saddr] <= {ssh[6:0], MOSI};
                    default:      sbyte <= smem[saddr];
                endcase
            end
            if (scnt >= 13 && scnt <= 20) MISO <= sbyte[3'(20 - scnt)];
            else MISO <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            acc_q.delete();
        end else if (req_valid && req_ready) begin
            acc_q.push_back(cyc);
            n_acc    <= n_acc + 1;
            last_acc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_t e;
            int   a;
            e = 'x;
            a = -1000;
            if (exp_rsp.size() > 0) e = exp_rsp.pop_front();
            if (acc_q.size() > 0) a = acc_q.pop_front();
            check("rsp_wr", 32'(rsp_wr), 32'(e.wr));
            check("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
            check("rsp_latency", 32'(cyc - a), 32'(e.lat));
            last_rsp_cyc = cyc;
            n_rsp++;
        end
    end

    task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic hold);
        int   n;
        rsp_t r;
        exp_frm.push_back({~wr, 1'b0, a});
        exp_frm.push_back(wr ? {2'b01, d} : {2'b11, 8'h00});
        if (wr) begin
            ref_mem[a] = d;
        end else begin
            last_rd = ref_mem[a];
        end
        r.wr  = wr;
        r.rd  = last_rd;
        r.lat = wr ? 8'd26 : 8'd36;
        exp_rsp.push_back(r);
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || busy !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 400), 32'd1);
    endtask

    initial begin
        int snap;

        // reset
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_wr", 32'(rsp_wr), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ss_n", 32'(SS_n), 32'd1);

        // write then read back
        send(1'b1, 8'h03, 8'h55, 1'b0);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_idle();
        check("slave_mem3", 32'(smem[3]), 32'h55);
        send(1'b0, 8'h03, 8'h00, 1'b0);
        wait_idle();

        // back-to-back with req_valid held
        send(1'b1, 8'h10, 8'hA5, 1'b1);
        send(1'b0, 8'h10, 8'h00, 1'b0);
        check("b2b_accept_on_rsp", 32'(last_acc), 32'(last_rsp_cyc));
        wait_idle();

        // request fields change while busy; extra pulse not accepted
        send(1'b1, 8'h20, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        req_addr  = 8'hEE;
        req_wdata = 8'h11;
        req_wr    = 1'b0;
        snap      = n_acc;
        req_valid = 1'b1;
        check("busy_ready_low", 32'(req_ready), 32'd0);
        check("busy_high", 32'(busy), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_no_accept", 32'(n_acc), 32'(snap));
        repeat (15) @(negedge clk);
        req_addr  = 8'h01;
        req_wdata = 8'h77;
        wait_idle();
        send(1'b0, 8'h20, 8'h00, 1'b0);
        wait_idle();

        // boundary addresses and data
        send(1'b1, 8'hFF, 8'h00, 1'b0);
        wait_idle();
        send(1'b0, 8'hFF, 8'h00, 1'b0);
        wait_idle();
        send(1'b1, 8'h00, 8'hFF, 1'b0);
        wait_idle();
        send(1'b0, 8'h00, 8'h00, 1'b0);
        wait_idle();

        // reset during SHIFT of frame 1 aborts without a response
        req_wr    = 1'b1;
        req_addr  = 8'h40;
        req_wdata = 8'h99;
        req_valid = 1'b1;
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_ss_low", 32'(SS_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ss_high", 32'(SS_n), 32'd1);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        check("abort_ready_back", 32'(req_ready), 32'd1);
        rst = 1'b0;
        last_rd = 8'h00;
        snap = n_rsp;
        repeat (40) @(negedge clk);
        check("abort_rsp_count", 32'(n_rsp), 32'(snap));
        check("abort_mem_untouched", 32'(smem[8'h40]), 32'h00);
        send(1'b0, 8'h40, 8'h00, 1'b0);
        wait_idle();
        check("frames_drained", 32'(exp_frm.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
